int_divider_seq: RTL and testbench

Parametrised multi-cycle radix-2 restoring integer divider with full AXI-Stream handshakes on both operand channels and the result channel. It is the successor to the fixed 16/16 always-valid divider core. It adds width generics, signed/unsigned mode, output backpressure and a divide-by-zero flag. It sits in the fpga_cnn datapath wherever average-pooling and normalisation stages need quotient/remainder pairs and can tolerate multi-cycle latency.

---
 rtl/div_pkg.sv | 29 ++
 rtl/div_step.sv | 27 ++
 rtl/int_divider_seq.sv | 147 ++++++++++++++
 tb/tb_int_divider_seq.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential integer divider: FSM encoding,
// iteration-counter sizing and result field positions inside tdata.
package div_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter must hold DIVIDEND_W-1; never narrower than one bit.
    function automatic int cnt_width(input int dividend_w);
        return (dividend_w > 1) ? $clog2(dividend_w) : 1;
    endfunction

    // Result layout: {quotient, remainder}, remainder in the low bits.
    localparam int REM_LSB = 0;

    function automatic int rem_msb(input int divisor_w);
        return divisor_w - 1;
    endfunction

    function automatic int quot_lsb(input int divisor_w);
        return divisor_w;
    endfunction

    function automatic int quot_msb(input int dividend_w, input int divisor_w);
        return dividend_w + divisor_w - 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, trial-subtract the divisor, keep the difference when it is non-negative.
module div_step #(
    parameter int DIVISOR_W = 16
) (
    input  logic [DIVISOR_W:0]   rem_in,
    input  logic                 dvd_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_out,
    output logic                 q_bit
);

    localparam int EW = DIVISOR_W + 2;
    localparam int RW = DIVISOR_W + 1;

    logic [EW-1:0] ext;
    logic [EW-1:0] dvs;

    // Trial subtraction on a widened remainder so no bit is lost in the shift.
    always_comb begin
        ext     = {rem_in, dvd_bit};
        dvs     = EW'(divisor);
        q_bit   = (ext >= dvs);
        rem_out = q_bit ? RW'(ext - dvs) : RW'(ext);
    end

endmodule

// File: rtl/int_divider_seq.sv
// Multi-cycle radix-2 restoring divider with AXI-Stream operand and result
// channels. One quotient bit per cycle, optional two's-complement mode.
module int_divider_seq
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 16,
    parameter int SIGNED     = 0
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            s_axis_dividend_tvalid,
    output logic                            s_axis_dividend_tready,
    input  logic [DIVIDEND_W-1:0]           s_axis_dividend_tdata,
    input  logic                            s_axis_divisor_tvalid,
    output logic                            s_axis_divisor_tready,
    input  logic [DIVISOR_W-1:0]            s_axis_divisor_tdata,
    output logic                            m_axis_dout_tvalid,
    input  logic                            m_axis_dout_tready,
    output logic [DIVIDEND_W+DIVISOR_W-1:0] m_axis_dout_tdata,
    output logic                            m_axis_dout_tuser
);

    localparam int CW = cnt_width(DIVIDEND_W);

    logic [1:0]                      state_q;
    logic                            rdy_q;
    logic [CW-1:0]                   cnt_q;
    logic                            fin_q;
    logic [DIVIDEND_W-1:0]           dvd_q;     // dividend shifts out, quotient shifts in
    logic [DIVISOR_W-1:0]            dsr_q;
    logic [DIVISOR_W:0]              rem_q;
    logic                            sgn_n_q;
    logic                            sgn_d_q;
    logic                            dz_q;
    logic [DIVISOR_W-1:0]            raw_q;     // raw dividend bits for the divide-by-zero result
    logic [DIVIDEND_W+DIVISOR_W-1:0] tdata_q;
    logic                            tuser_q;

    logic                            accept;
    logic                            dvd_neg;
    logic                            dsr_neg;
    logic [DIVIDEND_W-1:0]           dvd_mag;
    logic [DIVISOR_W-1:0]            dsr_mag;
    logic [DIVISOR_W:0]              rem_nxt;
    logic                            q_bit;
    logic [DIVIDEND_W-1:0]           q_fix;
    logic [DIVISOR_W-1:0]            r_fix;

    assign s_axis_dividend_tready = rdy_q;
    assign s_axis_divisor_tready  = rdy_q;
    assign m_axis_dout_tvalid     = (state_q == ST_DONE);
    assign m_axis_dout_tdata      = tdata_q;
    assign m_axis_dout_tuser      = tuser_q;

    // Joined handshake plus operand magnitudes (negation wraps most-negative onto itself).
    always_comb begin
        accept  = rdy_q && s_axis_dividend_tvalid && s_axis_divisor_tvalid;
        dvd_neg = (SIGNED != 0) && s_axis_dividend_tdata[DIVIDEND_W-1];
        dsr_neg = (SIGNED != 0) && s_axis_divisor_tdata[DIVISOR_W-1];
        dvd_mag = dvd_neg ? (~s_axis_dividend_tdata + DIVIDEND_W'(1)) : s_axis_dividend_tdata;
        dsr_mag = dsr_neg ? (~s_axis_divisor_tdata + DIVISOR_W'(1)) : s_axis_divisor_tdata;
    end

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem_in  (rem_q),
        .dvd_bit (dvd_q[DIVIDEND_W-1]),
        .divisor (dsr_q),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    // Sign correction of the finished magnitudes; zero divisor overrides everything.
    always_comb begin
        q_fix = (sgn_n_q ^ sgn_d_q) ? (~dvd_q + DIVIDEND_W'(1)) : dvd_q;
        r_fix = sgn_n_q ? (~rem_q[DIVISOR_W-1:0] + DIVISOR_W'(1)) : rem_q[DIVISOR_W-1:0];
        if (dz_q) begin
            q_fix = '1;
            r_fix = raw_q;
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b0;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            sgn_n_q <= 1'b0;
            sgn_d_q <= 1'b0;
            dz_q    <= 1'b0;
            raw_q   <= '0;
            tdata_q <= '0;
            tuser_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rdy_q <= 1'b1;
                    if (accept) begin
                        rdy_q   <= 1'b0;
                        dvd_q   <= dvd_mag;
                        dsr_q   <= dsr_mag;
                        rem_q   <= '0;
                        cnt_q   <= CW'(DIVIDEND_W - 1);
                        fin_q   <= 1'b0;
                        sgn_n_q <= dvd_neg;
                        sgn_d_q <= dsr_neg;
                        dz_q    <= (s_axis_divisor_tdata == '0);
                        raw_q   <= s_axis_dividend_tdata[DIVISOR_W-1:0];
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (!fin_q) begin
                        rem_q <= rem_nxt;
                        dvd_q <= {dvd_q[DIVIDEND_W-2:0], q_bit};
                        if (cnt_q == '0) begin
                            fin_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end else begin
                        tdata_q <= {q_fix, r_fix};
                        tuser_q <= dz_q;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (m_axis_dout_tready) begin
                        rdy_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_divider_seq.sv
// Self-checking bench: three divider instances (unsigned 16/16, signed 16/16,
// unsigned 24/8) driven from a vector table plus random and reset sequences.
module tb_int_divider_seq;

    logic clk;
    logic aresetn;

    logic [2:0]        dvd_valid;
    logic [2:0]        dsr_valid;
    logic [2:0]        dout_ready;
    logic [2:0][31:0]  dvd_data;
    logic [2:0][15:0]  dsr_data;
    wire  [2:0]        dvd_rdy;
    wire  [2:0]        dsr_rdy;
    wire  [2:0]        dout_valid;
    wire  [2:0]        dout_user;
    wire  [2:0][31:0]  dout_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          inst;
        logic [31:0] q;
        logic [31:0] r;
        logic        u;
    } exp_t;

    typedef struct {
        int          inst;
        logic [31:0] a;
        logic [15:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        u;
        int          lead;
        int          hold;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];

    int_divider_seq u_dut_u16 (
        .aclk                   (clk),
        .aresetn                (aresetn),
        .s_axis_dividend_tvalid (dvd_valid[0]),
        .s_axis_dividend_tready (dvd_rdy[0]),
        .s_axis_dividend_tdata  (dvd_data[0][15:0]),
        .s_axis_divisor_tvalid  (dsr_valid[0]),
        .s_axis_divisor_tready  (dsr_rdy[0]),
        .s_axis_divisor_tdata   (dsr_data[0]),
        .m_axis_dout_tvalid     (dout_valid[0]),
        .m_axis_dout_tready     (dout_ready[0]),
        .m_axis_dout_tdata      (dout_data[0]),
        .m_axis_dout_tuser      (dout_user[0])
    );

    int_divider_seq #(
        .DIVIDEND_W (16),
        .DIVISOR_W  (16),
        .SIGNED     (1)
    ) u_dut_s16 (
        .aclk                   (clk),
        .aresetn                (aresetn),
        .s_axis_dividend_tvalid (dvd_valid[1]),
        .s_axis_dividend_tready (dvd_rdy[1]),
        .s_axis_dividend_tdata  (dvd_data[1][15:0]),
        .s_axis_divisor_tvalid  (dsr_valid[1]),
        .s_axis_divisor_tready  (dsr_rdy[1]),
        .s_axis_divisor_tdata   (dsr_data[1]),
        .m_axis_dout_tvalid     (dout_valid[1]),
        .m_axis_dout_tready     (dout_ready[1]),
        .m_axis_dout_tdata      (dout_data[1]),
        .m_axis_dout_tuser      (dout_user[1])
    );

    int_divider_seq #(
        .DIVIDEND_W (24),
        .DIVISOR_W  (8),
        .SIGNED     (0)
    ) u_dut_u24 (
        .aclk                   (clk),
        .aresetn                (aresetn),
        .s_axis_dividend_tvalid (dvd_valid[2]),
        .s_axis_dividend_tready (dvd_rdy[2]),
        .s_axis_dividend_tdata  (dvd_data[2][23:0]),
        .s_axis_divisor_tvalid  (dsr_valid[2]),
        .s_axis_divisor_tready  (dsr_rdy[2]),
        .s_axis_divisor_tdata   (dsr_data[2][7:0]),
        .m_axis_dout_tvalid     (dout_valid[2]),
        .m_axis_dout_tready     (dout_ready[2]),
        .m_axis_dout_tdata      (dout_data[2]),
        .m_axis_dout_tuser      (dout_user[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d",
                 checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] got_q(input int inst);
        return (inst == 2) ? {8'h0, dout_data[2][31:8]} : {16'h0, dout_data[inst][31:16]};
    endfunction

    function automatic logic [31:0] got_r(input int inst);
        return (inst == 2) ? {24'h0, dout_data[2][7:0]} : {16'h0, dout_data[inst][15:0]};
    endfunction

    // Called just after a rising edge; leaves the bench just after a rising edge.
    task automatic run_op(input int inst, input logic [31:0] a, input logic [15:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic eu,
                          input int lead, input int hold);
        exp_t        e;
        int          n;
        int          w;
        logic        ok;
        logic [31:0] snap;
        w = (inst == 2) ? 24 : 16;
        e.inst = inst;
        e.q    = eq;
        e.r    = er;
        e.u    = eu;
        sb.push_back(e);
        dout_ready[inst] = (hold == 0);
        dvd_valid[inst]  = 1'b1;
        dvd_data[inst]   = a;
        if (lead > 0) begin
            ok = 1'b1;
            repeat (lead) begin
                @(posedge clk);
                #1;
                if (!dvd_rdy[inst] || dout_valid[inst]) ok = 1'b0;
            end
            chk("join_single_valid_not_consumed", {31'h0, ok}, 32'h1);
        end
        dsr_valid[inst] = 1'b1;
        dsr_data[inst]  = b;
        n = 0;
        while (!(dvd_rdy[inst] && dsr_rdy[inst]) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            chk("accept_timeout", 32'h0, 32'h1);
            void'(sb.pop_front());
            dvd_valid[inst] = 1'b0;
            dsr_valid[inst] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        dvd_valid[inst] = 1'b0;
        dsr_valid[inst] = 1'b0;
        dvd_data[inst]  = $urandom;
        dsr_data[inst]  = 16'($urandom);
        chk("tready_low_after_accept", {31'h0, dvd_rdy[inst] | dsr_rdy[inst]}, 32'h0);
        n = 0;
        while (!dout_valid[inst] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = sb.pop_front();
        if (n >= 100) begin
            chk("result_timeout", 32'h0, 32'h1);
            return;
        end
        chk("latency", n, w + 1);
        chk("quotient", got_q(e.inst), e.q);
        chk("remainder", got_r(e.inst), e.r);
        chk("tuser", {31'h0, dout_user[e.inst]}, {31'h0, e.u});
        if (hold > 0) begin
            snap = dout_data[inst];
            ok   = 1'b1;
            repeat (hold) begin
                @(posedge clk);
                #1;
                if (dout_data[inst] !== snap || !dout_valid[inst] || dvd_rdy[inst] ||
                    dsr_rdy[inst]) ok = 1'b0;
            end
            chk("backpressure_stall_stable", {31'h0, ok}, 32'h1);
        end
        dout_ready[inst] = 1'b1;
        @(posedge clk);
        #1;
        chk("post_handshake_state",
            {29'h0, dout_valid[inst], dvd_rdy[inst], dsr_rdy[inst]}, 32'h3);
    endtask

    initial begin
        logic [15:0] a16;
        logic [15:0] b16;
        int          sa;
        int          sb_i;
        int          qi;
        int          ri;
        logic [31:0] qv;
        logic [31:0] rv;
        logic        ok;

        aresetn    = 1'b0;
        dvd_valid  = '0;
        dsr_valid  = '0;
        dout_ready = '1;
        dvd_data   = '0;
        dsr_data   = '0;

        // inst, dividend, divisor, q, r, tuser, dividend lead cycles, backpressure cycles
        tbl.push_back('{0, 32'd100,      16'd50,     32'd2,        32'd0,      1'b0, 0, 0});
        tbl.push_back('{0, 32'd120,      16'd3,      32'd40,       32'd0,      1'b0, 0, 0});
        tbl.push_back('{0, 32'd100,      16'd3,      32'd33,       32'd1,      1'b0, 0, 0});
        tbl.push_back('{0, 32'd7,        16'd4,      32'd1,        32'd3,      1'b0, 0, 0});
        tbl.push_back('{0, 32'd55,       16'd0,      32'hFFFF,     32'd55,     1'b1, 0, 0});
        tbl.push_back('{0, 32'd9,        16'd3,      32'd3,        32'd0,      1'b0, 0, 0});
        tbl.push_back('{0, 32'd1234,     16'd10,     32'd123,      32'd4,      1'b0, 5, 0});
        tbl.push_back('{0, 32'd5000,     16'd7,      32'd714,      32'd2,      1'b0, 0, 10});
        tbl.push_back('{0, 32'hFFFF,     16'hFFFF,   32'd1,        32'd0,      1'b0, 0, 0});
        tbl.push_back('{1, 32'hFFF9,     16'd2,      32'hFFFD,     32'hFFFF,   1'b0, 0, 0});
        tbl.push_back('{1, 32'd7,        16'hFFFE,   32'hFFFD,     32'd1,      1'b0, 0, 0});
        tbl.push_back('{1, 32'h8000,     16'hFFFF,   32'h8000,     32'd0,      1'b0, 0, 0});
        tbl.push_back('{1, 32'hFFFB,     16'd0,      32'hFFFF,     32'hFFFB,   1'b1, 0, 0});
        tbl.push_back('{2, 32'd1000000,  16'd255,    32'd3921,     32'd145,    1'b0, 0, 0});
        tbl.push_back('{2, 32'h123456,   16'd0,      32'hFFFFFF,   32'h56,     1'b1, 0, 0});
        tbl.push_back('{2, 32'hFFFFFF,   16'd1,      32'hFFFFFF,   32'd0,      1'b0, 0, 0});

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_tready", {30'h0, dvd_rdy[i], dsr_rdy[i]}, 32'h0);
            chk("reset_tvalid_tuser", {30'h0, dout_valid[i], dout_user[i]}, 32'h0);
            chk("reset_tdata", dout_data[i], 32'h0);
        end
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        chk("tready_after_release", {29'h0, dvd_rdy}, 32'h7);

        foreach (tbl[i]) begin
            run_op(tbl[i].inst, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].u,
                   tbl[i].lead, tbl[i].hold);
        end

        for (int i = 0; i < 4; i++) begin
            a16 = 16'($urandom);
            b16 = 16'($urandom_range(1, (i < 2) ? 300 : 65535));
            qv  = {16'h0, a16 / b16};
            rv  = {16'h0, a16 % b16};
            run_op(0, {16'h0, a16}, b16, qv, rv, 1'b0, 0, 0);
        end
        for (int i = 0; i < 4; i++) begin
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            if (b16 == 16'h0) b16 = 16'h3;
            sa   = int'($signed(a16));
            sb_i = int'($signed(b16));
            qi   = sa / sb_i;
            ri   = sa % sb_i;
            qv   = {16'h0, qi[15:0]};
            rv   = {16'h0, ri[15:0]};
            run_op(1, {16'h0, a16}, b16, qv, rv, 1'b0, 0, 0);
        end

        // Reset in the middle of a calculation: the in-flight result must vanish.
        dout_ready[0] = 1'b1;
        dvd_valid[0]  = 1'b1;
        dvd_data[0]   = 32'd200;
        dsr_valid[0]  = 1'b1;
        dsr_data[0]   = 16'd7;
        @(posedge clk);
        #1;
        dvd_valid[0] = 1'b0;
        dsr_valid[0] = 1'b0;
        chk("abort_op_accepted", {31'h0, dvd_rdy[0]}, 32'h0);
        repeat (7) @(posedge clk);
        #2;
        aresetn = 1'b0;
        #1;
        chk("async_reset_tdata", dout_data[0], 32'h0);
        chk("async_reset_flags", {29'h0, dout_valid[0], dout_user[0], dvd_rdy[0]}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        aresetn = 1'b1;
        ok = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (dout_valid[0]) ok = 1'b0;
        end
        chk("aborted_result_never_presented", {31'h0, ok}, 32'h1);
        run_op(0, 32'd100, 16'd3, 32'd33, 32'd1, 1'b0, 0, 0);

        chk("scoreboard_drained", sb.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
